pe_fifo: RTL and testbench
==========================

PE_FIFO -- requirements
Module: pe_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning payload bit width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning entry count; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn, input, 1, meaning reset; synchronous, active-low.
REQ-005 SHALL have port flush, input, 1, meaning synchronous clear of all entries.
REQ-006 SHALL have port in_valid, input, 1, meaning producer offers in_data.
REQ-007 SHALL have port in_ready, output, 1, meaning the FIFO accepts data this cycle.
REQ-008 SHALL have port in_data, input, DATA_WIDTH, meaning write payload.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data holds the head entry.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer (PE operand register) takes the head.
REQ-011 SHALL have port out_data, output, DATA_WIDTH, meaning the head entry.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, meaning occupancy 0..DEPTH.
REQ-013 SHALL have ports full and empty, output, 1 each, meaning count==DEPTH and count==0.

Function
REQ-014 Push SHALL occur when in_valid && in_ready; in_ready SHALL equal !full, independent of out_ready.
REQ-015 Pop SHALL occur when out_valid && out_ready; out_valid SHALL equal !empty.
REQ-016 Operation SHALL be first-word-fall-through: out_data SHALL show the head combinationally from storage.
REQ-017 Latency SHALL be one cycle: data pushed at edge N SHALL be visible with out_valid=1 after edge N, when the FIFO was empty.
REQ-018 Order SHALL be strict FIFO; no entry is lost or duplicated.
REQ-019 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without extra logic.
REQ-020 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-021 When full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-022 When empty, out_data SHALL be don't-care, and a pop request SHALL be ignored with no pointer or count change.
REQ-023 flush=1 SHALL zero both pointers and count at the next edge, taking priority over push and pop in that cycle.
REQ-024 Throughput SHALL be one push and one pop per cycle sustained when neither full nor empty.

Reset
REQ-025 With rstn=0 at a rising edge, pointers and count SHALL be 0; hence empty=1, full=0, out_valid=0, in_ready=1.
REQ-026 Reset SHALL have priority over flush, push and pop.
REQ-027 Reset mid-operation SHALL discard all held entries.
REQ-028 The storage array SHALL NOT be reset.

Structure
REQ-029 Default DATA_WIDTH and DEPTH constants SHALL live in the shared package, eyeriss_pkg, as PE_DATA_WIDTH and PE_FIFO_DEPTH.
REQ-030 Storage SHALL be a reg array with write enable = push, addressed by the write pointer.
REQ-031 One sub-module SHALL exist: pe_fifo_ctrl, holding the pointers, count, full and empty; pe_fifo instantiates it plus the array.
REQ-032 Implementation SHALL use no async reset and no latches; its size target is 120-400 lines total.

Verification
REQ-033 Reset then push 0x0001..0x0008 with out_ready=0 -> count=8, full=1, in_ready=0; a 9th push (0x0009) is refused.
REQ-034 Then out_ready=1 for 8 cycles -> out_data reads 0x0001..0x0008 in order, then empty=1 and out_valid=0.
REQ-035 Full FIFO with in_valid=1 and out_ready=1 -> a pop occurs, there is no push, and count goes 8->7.
REQ-036 Count=3 with simultaneous push and pop for 20 cycles -> count stays 3, pointers wrap, and data order is preserved.
REQ-037 Count=5 with flush=1 and in_valid=1 together -> next cycle count=0 and empty=1; the pushed word is discarded.
REQ-038 rstn=0 asserted for one cycle mid-stream at count=4 -> next cycle count=0 and out_valid=0; a subsequent push of 0xBEEF appears at out_data one cycle later.

Source files
------------

// File: rtl/eyeriss_pkg.sv
// rtl/eyeriss_pkg.sv - shared constants for the processing-element datapath
package eyeriss_pkg;

    localparam int PE_DATA_WIDTH = 16;
    localparam int PE_FIFO_DEPTH = 8;

    // Encoding of a push/pop pair as seen by the occupancy counter.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/pe_fifo_ctrl.sv
// rtl/pe_fifo_ctrl.sv - pointer, occupancy and full/empty tracking for pe_fifo
module pe_fifo_ctrl
    import eyeriss_pkg::*;
#(
    parameter int DEPTH = PE_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic                       push,
    output logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    fifo_op_e      op;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Acceptance looks only at our own state, so a full FIFO refuses a push
    // even when the head is leaving in the same cycle.
    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;
    assign op   = fifo_op_e'({push, pop});

    always_comb begin
        count_d = count_q;
        unique case (op)
            FIFO_PUSH: count_d = count_q + CW'(1);
            FIFO_POP:  count_d = count_q - CW'(1);
            default:   count_d = count_q;
        endcase
    end

    // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wraps for free.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/pe_fifo.sv
// rtl/pe_fifo.sv - first-word-fall-through operand FIFO feeding a PE
module pe_fifo
    import eyeriss_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int DEPTH      = PE_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic                  push;
    logic                  pop;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    pe_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    assign out_data  = mem[rd_ptr];
    assign out_valid = !empty;
    assign in_ready  = !full;

endmodule

// File: tb/tb_pe_fifo.sv
// tb/tb_pe_fifo.sv - directed self-checking bench for pe_fifo
module tb_pe_fifo;

    localparam int DW = 16;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rstn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [3:0]    count;
    logic          full;
    logic          empty;

    int n_cmp = 0;
    int n_err = 0;

    pe_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [DW-1:0] exp);
        check(tag, {16'h0, out_data}, {16'h0, exp});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        rstn = 1'b1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Fill to capacity, then offer a ninth word that must be refused.
        for (int i = 1; i <= 8; i++) begin
            push_word(DW'(i));
            if (i == 1) begin
                check("latency_valid", 32'(out_valid), 1);
                check("latency_data", 32'(out_data), 32'h0001);
            end
        end
        check("fill_count", 32'(count), 8);
        check("fill_full", 32'(full), 1);
        check("fill_in_ready", 32'(in_ready), 0);
        push_word(16'h0009);
        check("refused_count", 32'(count), 8);
        check("refused_head", 32'(out_data), 32'h0001);

        for (int i = 1; i <= 8; i++) pop_check("drain_data", DW'(i));
        check("drain_empty", 32'(empty), 1);
        check("drain_out_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop_empty_count", 32'(count), 0);

        // Full with push and pop offered together: only the pop happens.
        for (int i = 0; i < 8; i++) push_word(16'h0011 + DW'(i));
        check("full2_head", 32'(out_data), 32'h0011);
        in_valid = 1'b1; in_data = 16'h0099; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("full_pp_count", 32'(count), 7);
        for (int i = 1; i < 8; i++) pop_check("full_pp_drain", 16'h0011 + DW'(i));
        check("full_pp_empty", 32'(empty), 1);

        // Steady streaming at occupancy 3 across several pointer wraps.
        for (int i = 0; i < 3; i++) push_word(16'h0100 + DW'(i));
        check("stream_start_count", 32'(count), 3);
        for (int k = 0; k < 20; k++) begin
            check("stream_data", 32'(out_data), 32'h0100 + 32'(k));
            in_valid = 1'b1; in_data = 16'h0103 + DW'(k); out_ready = 1'b1;
            step();
            check("stream_count", 32'(count), 3);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) pop_check("stream_tail", 16'h0114 + DW'(i));
        check("stream_end_empty", 32'(empty), 1);

        // Flush wins over a push in the same cycle.
        for (int i = 0; i < 5; i++) push_word(16'h0200 + DW'(i));
        check("pre_flush_count", 32'(count), 5);
        flush = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_out_valid", 32'(out_valid), 0);
        push_word(16'h0300);
        check("post_flush_data", 32'(out_data), 32'h0300);
        check("post_flush_count", 32'(count), 1);
        pop_check("post_flush_pop", 16'h0300);

        // Reset mid-stream discards held entries.
        for (int i = 0; i < 4; i++) push_word(16'h0400 + DW'(i));
        check("pre_rst_count", 32'(count), 4);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        push_word(16'hBEEF);
        check("beef_valid", 32'(out_valid), 1);
        check("beef_data", 32'(out_data), 32'hBEEF);
        check("beef_count", 32'(count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
